// File: rtl/pipelined_barrel_rotator.sv
// pipelined_barrel_rotator
//   Pipelined barrel rotator/shifter, one register stage per amount bit
//   (SHW = $clog2(WIDTH) stages). Stage k moves the word by 2^k when bit k
//   of its captured amount is set. Valid/ready on both sides, with a
//   per-stage ready chain so bubbles collapse.
//
//   Modes: 00 ROR, 01 ROL, 10 LSR (zero fill), 11 ASR (sign fill).
//   Build option: PIPELINED_BARREL_ROTATOR_ASR_EN
//     defined   -> mode 11 is an arithmetic right shift (fills with d_in MSB)
//     undefined -> sign-fill logic is absent and mode 11 behaves as LSR
//
//   Ports
//     clk, rst           clock, asynchronous active-high reset
//     in_valid/in_ready  input handshake (in_ready depends on out_ready)
//     d_in, amount, mode input word, distance 0..WIDTH-1, operation
//     out_valid/out_ready output handshake
//     d_out, out_zero    result, and (d_out == 0) qualified by out_valid
`timescale 1ns/1ps

// One fixed-distance shift/rotate step.
module pbr_shift #(
  parameter int WIDTH = 8,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic             fill,
  output logic [WIDTH-1:0] q
);
  localparam logic [WIDTH-1:0] ONES = '1;

  always_comb begin
    case (mode)
      2'b00:   q = (d >> DIST) | (d << (WIDTH - DIST));
      // left rotate by mirroring the right rotate
      2'b01:   q = (d << DIST) | (d >> (WIDTH - DIST));
      // fill is 1 only for ASR of a negative word; top DIST bits get set
      default: q = (d >> DIST) | (fill ? ~(ONES >> DIST) : '0);
    endcase
  end
endmodule

module pipelined_barrel_rotator #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           d_in,
  input  logic [$clog2(WIDTH)-1:0]   amount,
  input  logic [1:0]                 mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           d_out,
  output logic                       out_zero
);
  localparam int SHW = $clog2(WIDTH);

  // stage registers
  logic [SHW-1:0]                vld;
  logic [SHW-1:0][WIDTH-1:0]     dat;
  logic [SHW-1:0][SHW-1:0]       amt;
  logic [SHW-1:0][1:0]           md;
  logic                          zq;

  // per-stage inputs (previous stage or the ports) and results
  logic [SHW-1:0]                src_v;
  logic [SHW-1:0][WIDTH-1:0]     src_d;
  logic [SHW-1:0][SHW-1:0]       src_a;
  logic [SHW-1:0][1:0]           src_m;
  logic [SHW-1:0]                fil;
  logic [SHW-1:0][WIDTH-1:0]     res;
  logic [SHW-1:0][WIDTH-1:0]     nxt;
  logic [SHW:0]                  rdy;

`ifdef PIPELINED_BARREL_ROTATOR_ASR_EN
  // original sign bit travels with the word
  logic [SHW-1:0]                sgn;
  logic [SHW-1:0]                src_s;
`endif

  assign rdy[SHW] = out_ready;
  assign in_ready = rdy[0];

  genvar k;
  generate
    for (k = 0; k < SHW; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign src_v[k] = in_valid;
        assign src_d[k] = d_in;
        assign src_a[k] = amount;
        assign src_m[k] = mode;
`ifdef PIPELINED_BARREL_ROTATOR_ASR_EN
        assign src_s[k] = d_in[WIDTH-1];
`endif
      end else begin : g_body
        assign src_v[k] = vld[k-1];
        assign src_d[k] = dat[k-1];
        assign src_a[k] = amt[k-1];
        assign src_m[k] = md[k-1];
`ifdef PIPELINED_BARREL_ROTATOR_ASR_EN
        assign src_s[k] = sgn[k-1];
`endif
      end

`ifdef PIPELINED_BARREL_ROTATOR_ASR_EN
      assign fil[k] = (src_m[k] == 2'b11) && src_s[k];
`else
      assign fil[k] = 1'b0;
`endif

      // a stage can take a word when empty or when its word moves on
      assign rdy[k] = !vld[k] || rdy[k+1];

      pbr_shift #(.WIDTH(WIDTH), .DIST(1 << k)) u_shift (
        .d    (src_d[k]),
        .mode (src_m[k]),
        .fill (fil[k]),
        .q    (res[k])
      );

      assign nxt[k] = src_a[k][k] ? res[k] : src_d[k];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      dat <= '0;
      amt <= '0;
      md  <= '0;
      zq  <= 1'b0;
`ifdef PIPELINED_BARREL_ROTATOR_ASR_EN
      sgn <= '0;
`endif
    end else begin
      for (int i = 0; i < SHW; i++) begin
        if (rdy[i]) begin
          vld[i] <= src_v[i];
          // payload only moves with a real word; a stalled stage keeps its own
          if (src_v[i]) begin
            dat[i] <= nxt[i];
            amt[i] <= src_a[i];
            md[i]  <= src_m[i];
`ifdef PIPELINED_BARREL_ROTATOR_ASR_EN
            sgn[i] <= src_s[i];
`endif
          end
        end
      end
      // zero flag is registered alongside the final stage data
      if (rdy[SHW-1] && src_v[SHW-1])
        zq <= ~|nxt[SHW-1];
    end
  end

  assign out_valid = vld[SHW-1];
  assign d_out     = dat[SHW-1];
  assign out_zero  = zq && vld[SHW-1];

  // captured amount bits below the stage index and the last stage's
  // control fields are never consumed
  logic unused_ctrl;
`ifdef PIPELINED_BARREL_ROTATOR_ASR_EN
  assign unused_ctrl = ^{amt, md[SHW-1], sgn[SHW-1]};
`else
  assign unused_ctrl = ^{amt, md[SHW-1]};
`endif
endmodule

// File: tb/tb_pipelined_barrel_rotator.sv
// tb_pipelined_barrel_rotator
//   Directed vectors on an 8-bit instance (streaming, single ops, zero flag,
//   backpressure, mid-stream reset) plus random handshake traffic on 16- and
//   32-bit instances checked against a bitwise reference model.
`timescale 1ns/1ps

module tb_pipelined_barrel_rotator;
`ifdef PIPELINED_BARREL_ROTATOR_ASR_EN
  localparam bit ASR_ON = 1'b1;
`else
  localparam bit ASR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go  = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // bit-by-bit reference: result bit i picks a source bit of d
  function automatic logic [31:0] ref_rot(input int w, input logic [31:0] d,
                                          input int a, input logic [1:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (m)
        2'b00:   r[i] = d[(i + a) % w];
        2'b01:   r[i] = d[(i - a + w) % w];
        default: r[i] = (i + a < w) ? d[i + a] : ((ASR_ON && m == 2'b11) ? d[w-1] : 1'b0);
      endcase
    end
    return r;
  endfunction

  // ---------------- 8-bit directed instance ----------------
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_zero;
  logic [7:0] a_d_in, a_d_out;
  logic [2:0] a_amount;
  logic [1:0] a_mode;

  pipelined_barrel_rotator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .d_in(a_d_in), .amount(a_amount), .mode(a_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .d_out(a_d_out), .out_zero(a_out_zero)
  );

  logic [8:0] a_oq[$];   // {out_zero, d_out} per emitted word
  int         a_ocyc[$];
  int         a_nacc = 0;
  int         a_first_acc = -1;

  // transfers are decided by values stable between negedge and posedge
  always @(negedge clk) begin
    if (a_in_valid && a_in_ready) begin
      a_nacc++;
      if (a_first_acc < 0) a_first_acc = cyc;
    end
    if (a_out_valid && a_out_ready) begin
      a_oq.push_back({a_out_zero, a_d_out});
      a_ocyc.push_back(cyc);
    end
  end

  task automatic a_clear();
    a_oq.delete();
    a_ocyc.delete();
    a_nacc = 0;
    a_first_acc = -1;
  endtask

  task automatic a_drive(input logic v, input logic [7:0] d, input logic [2:0] am, input logic [1:0] m);
    a_in_valid = v;
    a_d_in     = d;
    a_amount   = am;
    a_mode     = m;
  endtask

  task automatic a_single(input string tag, input logic [7:0] d, input logic [2:0] am,
                          input logic [1:0] m, input logic [7:0] e);
    a_clear();
    a_drive(1'b1, d, am, m);
    tick();
    a_in_valid = 1'b0;
    repeat (5) tick();
    chk({tag, "_cnt"}, a_oq.size(), 1);
    if (a_oq.size() > 0) begin
      chk(tag, a_oq[0][7:0], e);
      chk({tag, "_zero"}, a_oq[0][8], (e == 8'h00));
    end
  endtask

  // ---------------- random instances ----------------
  for (genvar g = 0; g < 2; g++) begin : g_rand
    localparam int W  = (g == 0) ? 16 : 32;
    localparam int SW = $clog2(W);
    logic          iv, ir, ov, orr, oz;
    logic [W-1:0]  d, q;
    logic [SW-1:0] am;
    logic [1:0]    md;
    logic [31:0]   eq[$];
    logic [31:0]   ex;
    int            nacc = 0;
    int            nemit = 0;
    logic          done = 1'b0;

    pipelined_barrel_rotator #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(iv), .in_ready(ir),
      .d_in(d), .amount(am), .mode(md),
      .out_valid(ov), .out_ready(orr),
      .d_out(q), .out_zero(oz)
    );

    initial begin
      iv = 1'b0; orr = 1'b1; d = '0; am = '0; md = 2'b00;
      wait (go);
      tick();
      while (nacc < 1000) begin
        iv  = ($urandom_range(0, 3) != 0);
        orr = ($urandom_range(0, 3) != 0);
        d   = W'($urandom());
        if ($urandom_range(0, 15) == 0) d = '0;
        am  = SW'($urandom_range(0, W - 1));
        md  = 2'($urandom_range(0, 3));
        tick();
      end
      iv  = 1'b0;
      orr = 1'b1;
      for (int c = 0; c < 100 && nemit < 1000; c++) tick();
      chk($sformatf("r%0d_emitted", W), nemit, 1000);
      chk($sformatf("r%0d_leftover", W), eq.size(), 0);
      done = 1'b1;
    end

    always @(negedge clk) begin
      if (iv && ir) begin
        eq.push_back(ref_rot(W, 32'(d), int'(am), md));
        nacc++;
      end
      if (ov && orr) begin
        nemit++;
        if (eq.size() == 0) begin
          chk($sformatf("r%0d_extra", W), 1, 0);
        end else begin
          ex = eq.pop_front();
          chk($sformatf("r%0d_data", W), 32'(q), ex);
          chk($sformatf("r%0d_zero", W), 32'(oz), 32'(ex == 0));
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  logic [7:0] ror_tab [8] = '{8'h92, 8'h49, 8'hA4, 8'h52, 8'h29, 8'h94, 8'h4A, 8'h25};
  logic [7:0] bp_w    [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0] asr_exp;

  initial begin
    int idx;
    asr_exp = ASR_ON ? 8'hE4 : 8'h24;
    a_drive(1'b0, 8'h00, 3'd0, 2'b00);
    a_out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_d_out", a_d_out, 0);
    rst = 1'b0;
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_zero", a_out_zero, 0);

    // back-to-back ROR 0..7 of 10010010
    a_clear();
    for (int i = 0; i < 8; i++) begin
      a_drive(1'b1, 8'h92, 3'(i), 2'b00);
      tick();
    end
    a_in_valid = 1'b0;
    repeat (6) tick();
    chk("stream_cnt", a_oq.size(), 8);
    if (a_oq.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("stream_ror%0d", i), a_oq[i][7:0], ror_tab[i]);
        chk($sformatf("stream_zero%0d", i), a_oq[i][8], 0);
      end
      chk("stream_latency", a_ocyc[0] - a_first_acc, 3);
      chk("stream_rate", a_ocyc[7] - a_ocyc[0], 7);
    end

    // single operations and boundaries
    a_single("rol1",  8'h92, 3'd1, 2'b01, 8'h25);
    a_single("rol7",  8'h92, 3'd7, 2'b01, 8'h49);
    a_single("lsr4",  8'h92, 3'd4, 2'b10, 8'h09);
    a_single("asr2",  8'h92, 3'd2, 2'b11, asr_exp);
    a_single("asr2p", 8'h52, 3'd2, 2'b11, 8'h14);
    a_single("lsr0",  8'h92, 3'd0, 2'b10, 8'h92);
    a_single("asr0",  8'h92, 3'd0, 2'b11, 8'h92);
    a_single("zero_in", 8'h00, 3'd3, 2'b00, 8'h00);
    a_single("lsr01", 8'h01, 3'd1, 2'b10, 8'h00);

    // backpressure: five words offered, three absorbed
    a_clear();
    a_out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6 && idx < 5; c++) begin
      a_drive(1'b1, bp_w[idx], 3'd0, 2'b00);
      @(negedge clk);
      if (a_in_ready) idx++;
      tick();
    end
    @(negedge clk);
    chk("bp_accepted", idx, 3);
    chk("bp_in_ready", a_in_ready, 0);
    chk("bp_out_valid", a_out_valid, 1);
    chk("bp_head", a_d_out, 8'h11);
    tick();
    tick();
    chk("bp_hold", a_d_out, 8'h11);
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    #1;
    chk("bp_ready_back", a_in_ready, 1);
    repeat (5) tick();
    chk("bp_cnt", a_oq.size(), 3);
    if (a_oq.size() == 3) begin
      for (int i = 0; i < 3; i++)
        chk($sformatf("bp_word%0d", i), a_oq[i][7:0], bp_w[i]);
      chk("bp_rate", a_ocyc[2] - a_ocyc[0], 2);
    end

    // mid-stream reset with two words in flight
    a_clear();
    a_out_ready = 1'b0;
    a_drive(1'b1, 8'hA5, 3'd0, 2'b00);
    tick();
    a_drive(1'b1, 8'h5A, 3'd0, 2'b00);
    tick();
    a_in_valid = 1'b0;
    tick();
    chk("mid_pre_valid", a_out_valid, 1);
    chk("mid_pre_data", a_d_out, 8'hA5);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", a_out_valid, 0);
    chk("mid_rst_data", a_d_out, 0);
    tick();
    rst = 1'b0;
    a_out_ready = 1'b1;
    chk("mid_in_ready", a_in_ready, 1);
    a_clear();
    repeat (6) tick();
    chk("mid_flushed", a_oq.size(), 0);
    a_clear();
    a_drive(1'b1, 8'h3C, 3'd2, 2'b00);
    tick();
    a_in_valid = 1'b0;
    repeat (5) tick();
    chk("post_cnt", a_oq.size(), 1);
    if (a_oq.size() == 1) begin
      chk("post_data", a_oq[0][7:0], 8'h0F);
      chk("post_latency", a_ocyc[0] - a_first_acc, 3);
    end

    // random traffic on the wide instances
    go = 1'b1;
    for (int c = 0; c < 20000 && !(g_rand[0].done && g_rand[1].done); c++) tick();
    if (!(g_rand[0].done && g_rand[1].done))
      chk("rand_timeout", 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
